// File: rtl/dmem_responder_if.sv
// Load/store port between the CPU memory stage (master) and the data-memory
// responder (slave): request handshake, store/load controls and the response.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [1:0]  write_mem;
  logic [2:0]  read_mem;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] out_mem;

  modport master (
    output req_valid, address, write_data, write_mem, read_mem,
    input  req_ready, resp_valid, resp_err, out_mem
  );

  modport slave (
    input  req_valid, address, write_data, write_mem, read_mem,
    output req_ready, resp_valid, resp_err, out_mem
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, then a
// one-cycle response. Stores and loads commit at the edge that enters RESP.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          stateReg, stateNext;
  logic [CW-1:0]   cntReg, cntNext;
  logic [31:0]     addrReg, wdataReg;
  logic [1:0]      wmReg;
  logic [2:0]      rmReg;
  logic [31:0]     outReg;
  logic            errReg;

  logic            commit;
  logic [31:0]     curAddr, curWdata;
  logic [1:0]      curWm;
  logic [2:0]      curRm;
  logic            reqErr;
  logic [3:0]      laneWe;
  logic [31:0]     ramWord;
  logic [31:0]     loadData;
  logic [ADDR_WIDTH-1:0] wordIdx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg <= S_IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  always_comb begin
    stateNext      = stateReg;
    cntNext        = cntReg;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (stateReg)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          cntNext   = CW'(WAIT_CYCLES);
          stateNext = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cntNext = cntReg - CW'(1);
        if (cntReg == CW'(1)) stateNext = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        stateNext      = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addrReg  <= '0;
      wdataReg <= '0;
      wmReg    <= '0;
      rmReg    <= '0;
    end else if (stateReg == S_IDLE && bus.req_valid) begin
      addrReg  <= bus.address;
      wdataReg <= bus.write_data;
      wmReg    <= bus.write_mem;
      rmReg    <= bus.read_mem;
    end
  end

  // With zero wait states the commit edge is the accept edge, so use live inputs.
  assign curAddr  = (stateReg == S_IDLE) ? bus.address    : addrReg;
  assign curWdata = (stateReg == S_IDLE) ? bus.write_data : wdataReg;
  assign curWm    = (stateReg == S_IDLE) ? bus.write_mem  : wmReg;
  assign curRm    = (stateReg == S_IDLE) ? bus.read_mem   : rmReg;
  assign commit   = (stateNext == S_RESP) && (stateReg != S_RESP);
  assign wordIdx  = curAddr[ADDR_WIDTH+1:2];

  always_comb begin
    logic halfOp, wordOp;
    halfOp = (curRm == 3'b011) || (curRm == 3'b100) || (curWm == 2'b10);
    wordOp = (curRm == 3'b101) || (curWm == 2'b11);
    reqErr = (|curAddr[31:ADDR_WIDTH+2])
           | (halfOp & curAddr[0])
           | (wordOp & (|curAddr[1:0]))
           | ((|curWm) & (|curRm))
           | (curRm[2:1] == 2'b11);
  end

  // One byte-wide RAM per lane so partial stores need no read-modify-write.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic [7:0] laneRam [DEPTH];
    logic [7:0] laneByte;

    assign laneByte = (curWm == 2'b11) ? curWdata[8*gi +: 8] :
                      (curWm == 2'b10) ? curWdata[8*(gi%2) +: 8] : curWdata[7:0];
    assign laneWe[gi] = commit && !reqErr &&
                        ((curWm == 2'b11) ||
                         (curWm == 2'b10 && curAddr[1] == LANE[1]) ||
                         (curWm == 2'b01 && curAddr[1:0] == LANE));

    always_ff @(posedge clk) begin
      if (laneWe[gi]) laneRam[wordIdx] <= laneByte;
    end

    assign ramWord[8*gi +: 8] = laneRam[wordIdx];
  end

  always_comb begin
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    byteSel  = ramWord[{curAddr[1:0], 3'b000} +: 8];
    halfSel  = curAddr[1] ? ramWord[31:16] : ramWord[15:0];
    loadData = '0;
    case (curRm)
      3'b001:  loadData = {{24{byteSel[7]}}, byteSel};
      3'b010:  loadData = {24'b0, byteSel};
      3'b011:  loadData = {{16{halfSel[15]}}, halfSel};
      3'b100:  loadData = {16'b0, halfSel};
      3'b101:  loadData = ramWord;
      default: loadData = '0;
    endcase
    if (reqErr) loadData = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outReg <= '0;
      errReg <= 1'b0;
    end else if (commit) begin
      outReg <= loadData;
      errReg <= reqErr;
    end
  end

  assign bus.out_mem  = outReg;
  assign bus.resp_err = errReg;
endmodule

// File: tb/tb_dmem_responder.sv
// Drives two responders (2 and 0 wait states) with the same request stream and
// checks them every cycle against a byte-addressed memory model.
module tb_dmem_responder;
  localparam int AW = 10;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if ifA ();
  dmem_responder_if ifB ();

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dutB (.clk(clk), .rst(rst), .bus(ifB.slave));

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          skip = 1'b1;
  int          acc [2] = '{-100, -100};
  exp_t        expQ [2][$];
  logic [31:0] holdExp [2] = '{32'h0, 32'h0};
  logic [31:0] lastDutData [2];
  logic        lastDutErr [2];
  logic [7:0]  mdl [int unsigned];

  logic        rdy [2], rv [2], re [2];
  logic [31:0] om [2];
  assign rdy[0] = ifA.req_ready;  assign rdy[1] = ifB.req_ready;
  assign rv[0]  = ifA.resp_valid; assign rv[1]  = ifB.resp_valid;
  assign re[0]  = ifA.resp_err;   assign re[1]  = ifB.resp_err;
  assign om[0]  = ifA.out_mem;    assign om[1]  = ifB.out_mem;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wOf(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic setIf(input int i, input logic v, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] wm, input logic [2:0] rm);
    if (i == 0) begin
      ifA.req_valid = v; ifA.address = a; ifA.write_data = wd; ifA.write_mem = wm; ifA.read_mem = rm;
    end else begin
      ifB.req_valid = v; ifB.address = a; ifB.write_data = wd; ifB.write_mem = wm; ifB.read_mem = rm;
    end
  endtask

  // Reference: byte-addressed little-endian memory plus the error rules.
  task automatic modelOp(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] wm,
                         input logic [2:0] rm, output logic e, output logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    e = (a >= (32'd1 << (AW + 2)))
      || ((rm == 3 || rm == 4 || wm == 2) && (a % 2 != 0))
      || ((rm == 5 || wm == 3) && (a % 4 != 0))
      || (wm != 0 && rm != 0)
      || (rm >= 6);
    d = 32'h0;
    if (!e) begin
      case (rm)
        3'd1: begin b = mdl[a]; d = {{24{b[7]}}, b}; end
        3'd2: d = {24'h0, mdl[a]};
        3'd3: begin h = {mdl[a+1], mdl[a]}; d = {{16{h[15]}}, h}; end
        3'd4: d = {16'h0, mdl[a+1], mdl[a]};
        3'd5: d = {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]};
        default: d = 32'h0;
      endcase
      if (wm != 0)
        for (int k = 0; k < (1 << (wm - 1)); k++) mdl[a + k] = wd[8*k +: 8];
    end
  endtask

  // Called at a negedge; the request is accepted at the following edge.
  task automatic issue(input logic [1:0] mask, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] wm, input logic [2:0] rm,
                       input bit lit, input logic litErr, input logic [31:0] litData);
    logic        e;
    logic [31:0] d;
    modelOp(a, wd, wm, rm, e, d);
    $display("[TB] txn mask=%b addr=%h wdata=%h wm=%0d rm=%0d -> err=%0b data=%h",
             mask, a, wd, wm, rm, e, d);
    for (int i = 0; i < 2; i++)
      if (mask[i]) begin
        setIf(i, 1'b1, a, wd, wm, rm);
        expQ[i].push_back('{cyc + 1 + wOf(i), e, d});
        acc[i] = cyc + 1;
      end
    @(negedge clk);
    setIf(0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
    setIf(1, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
    // Junk requests while the slow responder is busy must be ignored.
    for (int k = 0; k < 3; k++) begin
      if (mask[0] && $urandom_range(0, 1) == 1)
        setIf(0, 1'b1, $urandom, $urandom, 2'($urandom), 3'($urandom));
      @(negedge clk);
    end
    setIf(0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
    if (lit)
      for (int i = 0; i < 2; i++)
        if (mask[i]) begin
          chk($sformatf("lit_err[%0d]@%h", i, a), 32'(lastDutErr[i]), 32'(litErr));
          chk($sformatf("lit_data[%0d]@%h", i, a), lastDutData[i], litData);
        end
  endtask

  always @(negedge clk) begin
    if (!skip)
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("req_ready[%0d]", i), 32'(rdy[i]),
            32'(!(cyc >= acc[i] && cyc <= acc[i] + wOf(i))));
        if (expQ[i].size() != 0 && expQ[i][0].cyc == cyc) begin
          chk($sformatf("resp_valid[%0d]", i), 32'(rv[i]), 32'h1);
          chk($sformatf("resp_err[%0d]", i), 32'(re[i]), 32'(expQ[i][0].err));
          chk($sformatf("out_mem[%0d]", i), om[i], expQ[i][0].data);
          holdExp[i]     = expQ[i][0].data;
          lastDutData[i] = om[i];
          lastDutErr[i]  = re[i];
          void'(expQ[i].pop_front());
        end else begin
          chk($sformatf("resp_valid_idle[%0d]", i), 32'(rv[i]), 32'h0);
          chk($sformatf("out_mem_hold[%0d]", i), om[i], holdExp[i]);
        end
      end
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  wm;
    logic [2:0]  rm;
    logic        e;
    logic [31:0] d;
    int          r;

    setIf(0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
    setIf(1, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ready[%0d]", i), 32'(rdy[i]), 32'h1);
      chk($sformatf("rst_valid[%0d]", i), 32'(rv[i]), 32'h0);
      chk($sformatf("rst_err[%0d]", i), 32'(re[i]), 32'h0);
      chk($sformatf("rst_out[%0d]", i), om[i], 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    skip = 1'b0;

    issue(2'b11, 32'h10, 32'hDEADBEEF, 2'b11, 3'b000, 1, 1'b0, 32'h0);
    issue(2'b11, 32'h10, 32'h0, 2'b00, 3'b101, 1, 1'b0, 32'hDEADBEEF);
    issue(2'b11, 32'h11, 32'h000000A5, 2'b01, 3'b000, 1, 1'b0, 32'h0);
    issue(2'b11, 32'h10, 32'h0, 2'b00, 3'b101, 1, 1'b0, 32'hDEADA5EF);
    issue(2'b11, 32'h11, 32'h0, 2'b00, 3'b001, 1, 1'b0, 32'hFFFFFFA5);
    issue(2'b11, 32'h11, 32'h0, 2'b00, 3'b010, 1, 1'b0, 32'h000000A5);
    issue(2'b11, 32'h12, 32'h00008234, 2'b10, 3'b000, 1, 1'b0, 32'h0);
    issue(2'b11, 32'h10, 32'h0, 2'b00, 3'b101, 1, 1'b0, 32'h8234A5EF);
    issue(2'b11, 32'h12, 32'h0, 2'b00, 3'b011, 1, 1'b0, 32'hFFFF8234);
    issue(2'b11, 32'h12, 32'h0, 2'b00, 3'b100, 1, 1'b0, 32'h00008234);
    issue(2'b11, 32'h13, 32'h0, 2'b00, 3'b011, 1, 1'b1, 32'h0);
    issue(2'b11, 32'h12, 32'h11111111, 2'b11, 3'b000, 1, 1'b1, 32'h0);
    issue(2'b11, 32'h10, 32'h0, 2'b00, 3'b101, 1, 1'b0, 32'h8234A5EF);
    issue(2'b11, 32'h1000, 32'h0, 2'b00, 3'b101, 1, 1'b1, 32'h0);
    issue(2'b11, 32'h10, 32'h0, 2'b11, 3'b101, 1, 1'b1, 32'h0);
    issue(2'b11, 32'h10, 32'h0, 2'b00, 3'b110, 1, 1'b1, 32'h0);
    issue(2'b11, 32'h10, 32'h0, 2'b00, 3'b000, 1, 1'b0, 32'h0);
    issue(2'b11, 32'h20, 32'h0BADF00D, 2'b11, 3'b000, 1, 1'b0, 32'h0);

    // Store to the slow responder, then reset it while the store is waiting.
    skip = 1'b1;
    $display("[TB] txn mask=01 addr=00000020 wdata=cafebabe wm=3 rm=0 -> aborted by reset");
    setIf(0, 1'b1, 32'h20, 32'hCAFEBABE, 2'b11, 3'b000);
    @(negedge clk);
    setIf(0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midrst_ready[%0d]", i), 32'(rdy[i]), 32'h1);
      chk($sformatf("midrst_valid[%0d]", i), 32'(rv[i]), 32'h0);
      chk($sformatf("midrst_out[%0d]", i), om[i], 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    acc[0] = -100; acc[1] = -100;
    holdExp[0] = 32'h0; holdExp[1] = 32'h0;
    @(negedge clk);
    skip = 1'b0;
    issue(2'b11, 32'h20, 32'h0, 2'b00, 3'b101, 1, 1'b0, 32'h0BADF00D);

    for (int w = 0; w < 16; w++)
      issue(2'b11, 32'h40 + 32'(4*w), $urandom, 2'b11, 3'b000, 0, 1'b0, 32'h0);
    for (int n = 0; n < 60; n++) begin
      a  = 32'h40 + 32'($urandom_range(0, 63));
      r  = $urandom_range(0, 9);
      wm = 2'b00;
      rm = 3'b000;
      if (r <= 2)      rm = 3'($urandom_range(1, 5));
      else if (r <= 5) wm = 2'($urandom_range(1, 3));
      else if (r == 7) begin wm = 2'($urandom_range(1, 3)); rm = 3'($urandom_range(1, 7)); end
      else if (r == 8) rm = 3'($urandom_range(6, 7));
      else if (r == 9) begin
        a  = a | (32'h1 << $urandom_range(AW + 2, 31));
        rm = 3'($urandom_range(1, 5));
      end
      issue(2'b11, a, $urandom, wm, rm, 0, 1'b0, 32'h0);
    end

    // Zero-wait responder with req_valid held across two requests.
    modelOp(32'h0, 32'h5, 2'b11, 3'b000, e, d);
    $display("[TB] txn mask=10 addr=00000000 wdata=00000005 wm=3 rm=0 -> err=%0b data=%h", e, d);
    setIf(1, 1'b1, 32'h0, 32'h5, 2'b11, 3'b000);
    expQ[1].push_back('{cyc + 1, e, d});
    acc[1] = cyc + 1;
    @(negedge clk);
    setIf(1, 1'b1, 32'h0, 32'h0, 2'b00, 3'b101);
    @(negedge clk);
    modelOp(32'h0, 32'h0, 2'b00, 3'b101, e, d);
    $display("[TB] txn mask=10 addr=00000000 wdata=00000000 wm=0 rm=5 -> err=%0b data=%h", e, d);
    expQ[1].push_back('{cyc + 1, e, d});
    acc[1] = cyc + 1;
    @(negedge clk);
    setIf(1, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
    @(negedge clk);
    chk("b2b_lw", lastDutData[1], 32'h00000005);

    repeat (3) @(negedge clk);
    chk("pendingA", 32'(expQ[0].size()), 32'h0);
    chk("pendingB", 32'(expQ[1].size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
